// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply/divide unit: command encoding, FSM states,
// and the per-operation sign bookkeeping latched at issue.
package hilo_pkg;

   typedef enum logic [2:0] {
      HL_MULT  = 3'd0,
      HL_MULTU = 3'd1,
      HL_DIV   = 3'd2,
      HL_DIVU  = 3'd3,
      HL_MTHI  = 3'd4,
      HL_MTLO  = 3'd5
   } hl_op_e;

   typedef enum logic [1:0] {
      HL_IDLE = 2'd0,
      HL_RUN  = 2'd1,
      HL_FIX  = 2'd2
   } hl_state_e;

   typedef struct packed {
      logic is_div;
      logic sa;
      logic sb;
      logic dz;
   } hl_flags_t;

   function automatic logic is_muldiv(input logic [2:0] op);
      return (op == HL_MULT) || (op == HL_MULTU) || (op == HL_DIV) || (op == HL_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == HL_MULT) || (op == HL_DIV);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == HL_DIV) || (op == HL_DIVU);
   endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Command/result bundle between the ALU control path and the HI/LO unit.
interface hilo_muldiv_if #(parameter int XLEN = 32);
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi_out;
   logic [XLEN-1:0] lo_out;

   modport master (output start, op, a, b, input busy, done, hi_out, lo_out);
   modport slave  (input start, op, a, b, output busy, done, hi_out, lo_out);
endinterface

// File: rtl/hilo_muldiv_step.sv
// One iteration of the mul/div engine: radix-2 shift-add for multiply,
// one restoring step for divide. Purely combinational.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   opnd,
   input  logic              is_div,
   output logic [2*XLEN-1:0] acc_nxt
);

   logic [XLEN:0] sum;
   logic [XLEN:0] rsh;
   logic [XLEN:0] diff;

   always_comb begin
      sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
      rsh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff = rsh - {1'b0, opnd};
      // Partial remainder stays below 2*divisor, so diff[XLEN] is a clean borrow flag.
      if (!is_div)
         acc_nxt = {sum, acc[XLEN-1:1]};
      else if (!diff[XLEN])
         acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         acc_nxt = {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
   end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative multiply/divide engine; results land
// XLEN+1 cycles after issue, MTHI/MTLO write in a single cycle.
module hilo_muldiv
   import hilo_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic           clk,
   input logic           reset,
   hilo_muldiv_if.slave  bus
);

   localparam int CW = $clog2(XLEN);

   hl_state_e          state, state_nxt;
   logic [2*XLEN-1:0]  acc, acc_step;
   logic [XLEN-1:0]    opnd;
   hl_flags_t          flg;
   logic [CW-1:0]      cnt;
   logic [XLEN-1:0]    hi, lo;
   logic               done_q;

   logic               accept_md, sgn_in, div_in, sa_in, sb_in;
   logic [XLEN-1:0]    ma, mb;
   logic [2*XLEN-1:0]  prod;
   logic [XLEN-1:0]    res_hi, res_lo;
   logic               busy_c, fix_c;

   always_comb begin
      accept_md = (state == HL_IDLE) && bus.start && is_muldiv(bus.op);
      sgn_in    = is_signed_op(bus.op);
      div_in    = is_div_op(bus.op);
      sa_in     = sgn_in & bus.a[XLEN-1];
      sb_in     = sgn_in & bus.b[XLEN-1];
      ma        = sa_in ? -bus.a : bus.a;
      mb        = sb_in ? -bus.b : bus.b;
   end

   muldiv_step #(.XLEN(XLEN)) u_step (
      .acc     (acc),
      .opnd    (opnd),
      .is_div  (flg.is_div),
      .acc_nxt (acc_step)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= HL_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         HL_IDLE: if (accept_md) state_nxt = HL_RUN;
         HL_RUN:  if (cnt == CW'(XLEN-1)) state_nxt = HL_FIX;
         HL_FIX:  state_nxt = HL_IDLE;
         default: state_nxt = HL_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      busy_c = 1'b0;
      fix_c  = 1'b0;
      case (state)
         HL_RUN:  busy_c = 1'b1;
         HL_FIX:  begin busy_c = 1'b1; fix_c = 1'b1; end
         default: ;
      endcase
   end

   // Multiplier sits in the low half and is consumed LSB first; the dividend
   // sits in the low half and is shifted into the remainder MSB first.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc  <= '0;
         opnd <= '0;
         flg  <= '0;
         cnt  <= '0;
      end else if (accept_md) begin
         acc  <= {{XLEN{1'b0}}, div_in ? ma : mb};
         opnd <= div_in ? mb : ma;
         flg  <= '{is_div: div_in, sa: sa_in, sb: sb_in, dz: (bus.b == '0)};
         cnt  <= '0;
      end else if (state == HL_RUN) begin
         acc  <= acc_step;
         cnt  <= cnt + 1'b1;
      end
   end

   // Divide-by-zero leaves quotient all ones and remainder = |a|; skipping the
   // quotient negation and keeping the remainder fixup recovers HI = a exactly.
   always_comb begin
      prod = (flg.sa ^ flg.sb) ? -acc : acc;
      if (flg.is_div) begin
         res_lo = (flg.sa ^ flg.sb) && !flg.dz ? -acc[XLEN-1:0] : acc[XLEN-1:0];
         res_hi = flg.sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      end else begin
         res_lo = prod[XLEN-1:0];
         res_hi = prod[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi     <= '0;
         lo     <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= fix_c;
         if (fix_c) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state == HL_IDLE && bus.start) begin
            if (bus.op == HL_MTHI) hi <= bus.a;
            if (bus.op == HL_MTLO) lo <= bus.a;
         end
      end
   end

   assign bus.busy   = busy_c;
   assign bus.done   = done_q;
   assign bus.hi_out = hi;
   assign bus.lo_out = lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomised and directed bench for hilo_muldiv against a plain-arithmetic model.
module tb_hilo_muldiv;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hilo_muldiv_if #(.XLEN(XLEN)) bus();
   hilo_muldiv #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;

   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint sa, sb, p, q, r;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = 32'd0;
      lo = 32'd0;
      case (op)
         3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
         3'd1: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
         3'd2: if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
               else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
         3'd3: if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
               else begin lo = a / b; hi = a % b; end
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'($urandom_range(0, 15));
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Issues one op and observes it until a few cycles past the expected write edge.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output int done_cyc, output int done_cnt,
                         output bit busy_bad, output bit hold_bad);
      logic [31:0] h0, l0;
      h0 = bus.hi_out; l0 = bus.lo_out;
      done_cyc = -1; done_cnt = 0; busy_bad = 0; hold_bad = 0; hi = 0; lo = 0;
      issue(op, a, b);
      for (int c = 0; c <= XLEN + 3; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (bus.busy !== 1'(c <= XLEN)) busy_bad = 1;
         if (bus.done === 1'b1) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
         if (c <= XLEN && (bus.hi_out !== h0 || bus.lo_out !== l0)) hold_bad = 1;
         if (c == XLEN + 1) begin hi = bus.hi_out; lo = bus.lo_out; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      checks++; if (bus.hi_out !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi_out); end
      checks++; if (bus.lo_out !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo_out); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
   endtask

   task automatic test_directed();
      logic [2:0]  t_op [7] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd2, 3'd3};
      logic [31:0] t_a  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100,
                                32'h8000_0000, 32'hFFFF_FFFB, 32'd1000};
      logic [31:0] t_b  [7] = '{32'hFFFF_FFFF, 32'd3, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd7};
      logic [31:0] t_hi [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100,
                                32'd0, 32'hFFFF_FFFB, 32'd6};
      logic [31:0] t_lo [7] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'h8000_0000, 32'hFFFF_FFFF, 32'd142};
      logic [31:0] hi, lo;
      int dc, dn;
      bit bb, hb;
      for (int i = 0; i < 7; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], hi, lo, dc, dn, bb, hb);
         checks++; if (hi !== t_hi[i]) begin errors++; $display("FAIL dir%0d_hi got %h exp %h", i, hi, t_hi[i]); end
         checks++; if (lo !== t_lo[i]) begin errors++; $display("FAIL dir%0d_lo got %h exp %h", i, lo, t_lo[i]); end
         checks++; if (dc !== XLEN + 1 || dn !== 1) begin errors++; $display("FAIL dir%0d_done got cyc %0d cnt %0d exp cyc %0d cnt 1", i, dc, dn, XLEN + 1); end
         checks++; if (bb || hb) begin errors++; $display("FAIL dir%0d_busy_hold got busy_bad %0d hold_bad %0d exp 0 0", i, bb, hb); end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, hi, lo, ehi, elo;
      logic [2:0]  op;
      int dc, dn;
      bit bb, hb;
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 3));
         a = rnd_val(); b = rnd_val();
         model(op, a, b, ehi, elo);
         run_op(op, a, b, hi, lo, dc, dn, bb, hb);
         checks++; if (hi !== ehi || lo !== elo) begin errors++; $display("FAIL rnd%0d op %0d a %h b %h got %h_%h exp %h_%h", i, op, a, b, hi, lo, ehi, elo); end
         checks++; if (dc !== XLEN + 1 || dn !== 1 || bb || hb) begin errors++; $display("FAIL rnd%0d_timing got cyc %0d cnt %0d busy_bad %0d hold_bad %0d exp %0d 1 0 0", i, dc, dn, bb, hb, XLEN + 1); end
      end
   endtask

   task automatic test_mt();
      logic [31:0] l0;
      bit busy_seen;
      l0 = bus.lo_out;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h1234_5678;
      @(posedge clk); #1;
      busy_seen = bus.busy;
      checks++; if (bus.hi_out !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got %h exp 12345678", bus.hi_out); end
      checks++; if (bus.lo_out !== l0) begin errors++; $display("FAIL mthi_lo_kept got %h exp %h", bus.lo_out, l0); end
      bus.op = 3'd5; bus.a = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      busy_seen |= bus.busy;
      checks++; if (bus.lo_out !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo_lo got %h exp 9abcdef0", bus.lo_out); end
      checks++; if (bus.hi_out !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_kept got %h exp 12345678", bus.hi_out); end
      @(posedge clk); #1;
      busy_seen |= bus.busy;
      checks++; if (busy_seen !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mt_busy_done got busy %b done %b exp 0 0", busy_seen, bus.done); end
      // Reserved op must leave everything alone.
      issue(3'd6, 32'hDEAD_BEEF, 32'd1);
      @(posedge clk); #1;
      checks++; if (bus.hi_out !== 32'h1234_5678 || bus.lo_out !== 32'h9ABC_DEF0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reserved_op got %h_%h busy %b exp 12345678_9abcdef0 0", bus.hi_out, bus.lo_out, bus.busy); end
   endtask

   task automatic test_ignore_busy();
      logic [31:0] ehi, elo;
      int dn, dc;
      model(3'd0, 32'hFFFF_FF00, 32'd1234, ehi, elo);
      issue(3'd0, 32'hFFFF_FF00, 32'd1234);
      repeat (5) @(posedge clk);
      #1;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEAD_0001;
      @(posedge clk); #1;
      bus.op = 3'd0; bus.a = 32'd2; bus.b = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      dn = 0; dc = -1;
      for (int c = 8; c <= XLEN + 3; c++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin dn++; if (dc < 0) dc = c; end
         if (c == XLEN + 1) begin
            checks++; if (bus.hi_out !== ehi || bus.lo_out !== elo) begin errors++; $display("FAIL ignore_result got %h_%h exp %h_%h", bus.hi_out, bus.lo_out, ehi, elo); end
         end
      end
      checks++; if (dn !== 1 || dc !== XLEN + 1) begin errors++; $display("FAIL ignore_done got cnt %0d cyc %0d exp 1 %0d", dn, dc, XLEN + 1); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] h1, l1, h2, l2;
      model(3'd1, 32'hCAFE_0000, 32'h0001_0003, h1, l1);
      model(3'd3, 32'hF000_0000, 32'd9, h2, l2);
      issue(3'd1, 32'hCAFE_0000, 32'h0001_0003);
      repeat (XLEN + 1) @(posedge clk);
      #1;
      checks++; if (bus.done !== 1'b1 || bus.hi_out !== h1 || bus.lo_out !== l1) begin errors++; $display("FAIL b2b_first got done %b %h_%h exp 1 %h_%h", bus.done, bus.hi_out, bus.lo_out, h1, l1); end
      bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'hF000_0000; bus.b = 32'd9;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b exp 1", bus.busy); end
      repeat (XLEN + 1) @(posedge clk);
      #1;
      checks++; if (bus.done !== 1'b1 || bus.hi_out !== h2 || bus.lo_out !== l2) begin errors++; $display("FAIL b2b_second got done %b %h_%h exp 1 %h_%h", bus.done, bus.hi_out, bus.lo_out, h2, l2); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] hi, lo;
      int dc, dn;
      bit bb, hb;
      issue(3'd4, 32'h5555_AAAA, 32'd0);
      issue(3'd5, 32'hAAAA_5555, 32'd0);
      issue(3'd3, 32'd1000, 32'd7);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_state got %h_%h busy %b exp 0_0 0", bus.hi_out, bus.lo_out, bus.busy); end
      dn = 0;
      for (int c = 0; c < XLEN + 4; c++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
      end
      checks++; if (dn !== 0 || bus.lo_out !== 32'd0) begin errors++; $display("FAIL midreset_quiet got activity %0d lo %h exp 0 0", dn, bus.lo_out); end
      run_op(3'd1, 32'd6, 32'd7, hi, lo, dc, dn, bb, hb);
      checks++; if (hi !== 32'd0 || lo !== 32'd42 || dn !== 1) begin errors++; $display("FAIL midreset_mul got %h_%h done %0d exp 0_2a 1", hi, lo, dn); end
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
      reset = 1'b1;
      test_reset();
      test_directed();
      test_mt();
      test_random();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
